// File: rtl/irq_aggregator_pkg.sv
// irq_pkg: shared constants for the interrupt aggregator.
//   - Avalon-MM register word addresses
//   - ACTIVE register layout (valid flag position, index width)
//   - bus widths and the largest supported number of interrupt lines
package irq_pkg;

  localparam int ADDR_W           = 3;
  localparam int DATA_W           = 16;
  localparam int IDX_W            = 4;
  localparam int NUM_IRQ_MAX      = 15;
  localparam int ACTIVE_VALID_BIT = 15;

  localparam logic [ADDR_W-1:0] ADDR_PENDING = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_ACTIVE  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_FORCE   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_ACK     = 3'd4;

endpackage

// File: rtl/irq_aggregator_if.sv
// irq_aggregator_if: Avalon-MM register bus of the interrupt aggregator.
//   address    : register word select
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data (slave drives)
// Handshake: no wait states. A write is taken on the rising edge where
// chipselect=1 and write_n=0. readdata is refreshed every cycle from the
// address sampled at that edge, so read data for the address presented at
// edge k is valid after edge k.
interface irq_aggregator_if;
  import irq_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata);

endinterface

// File: rtl/irq_aggregator_prio_enc.sv
// irq_prio_enc: combinational fixed-priority encoder, lowest index wins.
//   req   : request vector
//   idx   : index of the lowest set request bit (0 when none)
//   valid : at least one request bit set
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last to assign.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_aggregator.sv
// irq_aggregator: collects peripheral interrupt lines into one CPU interrupt.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   irq_in  : interrupt requests, active-high, synchronous to clk
//   bus     : Avalon-MM register slave (PENDING, MASK, ACTIVE, FORCE, ACK)
//   irq_out : registered OR of enabled pending lines
// Level lines track irq_in directly. Edge lines (EDGE_MASK bit set) latch a
// rising edge or a FORCE write and hold until W1C or ACK; a set beats a
// clear in the same cycle. NUM_IRQ must lie in 1..NUM_IRQ_MAX.
module irq_aggregator
  import irq_pkg::*;
#(
  parameter int               NUM_IRQ   = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  irq_aggregator_if.slave    bus,
  output logic               irq_out
);

  logic [NUM_IRQ-1:0] pending, pending_nxt;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] irq_in_d;
  logic [NUM_IRQ-1:0] edge_set, edge_clr;
  logic [NUM_IRQ-1:0] w1c_bits, force_bits, ack_hit;
  logic               wr_en;
  logic               wr_pending, wr_mask, wr_force, wr_ack;
  logic [IDX_W-1:0]   act_idx;
  logic               act_valid;
  logic [DATA_W-1:0]  rd_data;
  logic               unused_wd;

  assign unused_wd = ^bus.writedata;

  assign wr_en      = bus.chipselect & ~bus.write_n;
  assign wr_pending = wr_en & (bus.address == ADDR_PENDING);
  assign wr_mask    = wr_en & (bus.address == ADDR_MASK);
  assign wr_force   = wr_en & (bus.address == ADDR_FORCE);
  assign wr_ack     = wr_en & (bus.address == ADDR_ACK);

  assign w1c_bits   = wr_pending ? bus.writedata[NUM_IRQ-1:0] : '0;
  assign force_bits = wr_force   ? bus.writedata[NUM_IRQ-1:0] : '0;

  // ACK indices at or above NUM_IRQ match no bit and are dropped naturally.
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_hit[i] = wr_ack & (bus.writedata[IDX_W-1:0] == IDX_W'(i));
    end
  end

  assign edge_set = (irq_in & ~irq_in_d) | force_bits;
  assign edge_clr = w1c_bits | ack_hit;

  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!EDGE_MASK[i])    pending_nxt[i] = irq_in[i];
      else if (edge_set[i]) pending_nxt[i] = 1'b1;
      else if (edge_clr[i]) pending_nxt[i] = 1'b0;
    end
  end

  irq_prio_enc #(.N(NUM_IRQ)) u_prio_enc (
    .req   (pending & mask),
    .idx   (act_idx),
    .valid (act_valid)
  );

  always_comb begin
    rd_data = '0;
    case (bus.address)
      ADDR_PENDING: rd_data[NUM_IRQ-1:0] = pending;
      ADDR_MASK:    rd_data[NUM_IRQ-1:0] = mask;
      ADDR_ACTIVE: begin
        rd_data[ACTIVE_VALID_BIT] = act_valid;
        rd_data[IDX_W-1:0]        = act_idx;
      end
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= '0;
      mask         <= '0;
      irq_in_d     <= '0;
      irq_out      <= 1'b0;
      bus.readdata <= '0;
    end else begin
      pending      <= pending_nxt;
      irq_in_d     <= irq_in;
      irq_out      <= |(pending & mask);
      bus.readdata <= rd_data;
      if (wr_mask) mask <= bus.writedata[NUM_IRQ-1:0];
    end
  end

endmodule
